unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port (IF) and its load/store port (DM).
- Sits between the datapath and the memory macro.
- Arbitrates requests, issues one access at a time, tracks fixed memory latency, and routes each response back to the requester that owns it.
- Uses a req/gnt/rvalid handshake on both requester ports.

Parameters:
- AddressWidth, 10, word-address width of all address ports.
- DataWidth, 32, data width; byte enables are DataWidth/8 bits.
- MemLatency, 1, cycles from memory request to read data valid. Must be >= 1; 0 is rejected at elaboration.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request.
- if_addr_i  in  AddressWidth  fetch address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse).
- if_rdata_o  out  DataWidth  fetch data.
- dm_req_i  in  1  data request.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_be_i  in  DataWidth/8  byte enables (writes).
- dm_addr_i  in  AddressWidth  data address.
- dm_wdata_i  in  DataWidth  write data.
- dm_gnt_o  out  1  data request accepted this cycle.
- dm_rvalid_o  out  1  data response (read data or write ack), 1-cycle pulse.
- dm_rdata_o  out  DataWidth  load data.
- mem_req_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  DataWidth/8  memory byte enables.
- mem_addr_o  out  AddressWidth  memory address.
- mem_wdata_o  out  DataWidth  memory write data.
- mem_rdata_i  in  DataWidth  memory read data, valid MemLatency cycles after mem_req_o.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE, counter = 0, owner = IF, last_owner = IF.
  - All outputs are 0.
  - An in-flight access is abandoned and produces no rvalid after reset release.
- States:
  - IDLE: no access outstanding.
  - WAIT: access outstanding. A down-counter loads MemLatency-1 on grant and decrements each cycle.
- Grant window: the arbiter may grant when state == IDLE, or when state == WAIT and counter == 0 (the response cycle).
  - Giving a grant in the response cycle allows one access every MemLatency cycles with no bubble.
- Grant cycle (combinational in the same cycle):
  - Exactly one of if_gnt_o / dm_gnt_o is asserted, to the winner.
  - mem_req_o = 1, and the mem_* fields are muxed from the winner's inputs.
  - An IF grant forces mem_we_o = 0 and mem_be_o = 0.
  - On the clock edge: owner and the we flag are registered, counter loads MemLatency-1, state goes to WAIT.
- Response cycle (state WAIT, counter == 0):
  - The owner's rvalid is pulsed for 1 cycle.
  - The owner's rdata = mem_rdata_i for a read; 0 for a DM write.
  - The other port's rvalid and rdata are 0.
  - If there is no new grant, next state = IDLE.
- No request in the grant window: mem_req_o = 0 and both gnt outputs are 0.
- Requesters hold req and fields stable until gnt. The arbiter does not buffer ungranted requests. A req dropped before gnt is simply ignored.
- Conflict (both req in the grant window): the DM port wins (fixed priority) unless the optional feature is enabled.
- last_owner is updated on every grant.
- An rvalid and a gnt to the same port in the same cycle is legal and expected: back-to-back fetch.
- Outside the grant window, both gnt outputs = 0 and mem_req_o = 0.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on conflict the winner is the port not equal to last_owner. With reset last_owner = IF, DM wins the first conflict. Accesses alternate under sustained contention.
- Undefined: fixed priority with DM over IF. The last_owner register is unused and may be optimised away.

Test Plan:
- MemLatency = 1, IF only:
  - Stimulus: if_req_i held high, addresses 0x000, 0x001, 0x002; memory returns 0x00000013, 0x00100093, 0x00200113.
  - Expected: if_gnt_o high every cycle; if_rvalid_o high every cycle from cycle 1; rdata in order.
- MemLatency = 3, single DM read:
  - Stimulus: dm_req_i at cycle 0, addr 0x3FF; memory returns 0xDEADBEEF at cycle 3.
  - Expected: dm_gnt_o at cycle 0 only; dm_rvalid_o at cycle 3 only; dm_rdata_o = 0xDEADBEEF; no gnt at cycles 1–2.
- DM write:
  - Stimulus: we = 1, be = 4'b0011, wdata = 0x1234ABCD, addr 0x010.
  - Expected: mem_we_o = 1, mem_be_o = 4'b0011, mem_wdata_o = 0x1234ABCD in the grant cycle; dm_rvalid_o pulse with dm_rdata_o = 0.
- Simultaneous IF and DM requests held for 4 grants, MemLatency = 1:
  - Without the macro: DM, DM, DM, DM.
  - With ARB_ROUND_ROBIN_EN: DM, IF, DM, IF.
  - In both cases: if_rvalid_o and dm_rvalid_o are never high together.
- Reset mid-access:
  - Stimulus: MemLatency = 4, DM read granted at cycle 0, rst_ni low at cycle 2, released at cycle 3.
  - Expected: all outputs 0 immediately when rst_ni falls; no dm_rvalid_o at cycle 4; the next grant occurs normally.
- Request withdrawn:
  - Stimulus: if_req_i pulses for 1 cycle during WAIT (counter != 0), MemLatency = 2.
  - Expected: no if_gnt_o and no memory access for it.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Requester and memory-side signals of the unified memory arbiter.
// slave = arbiter side, master = requesters plus memory macro.
interface unified_mem_arbiter_if #(
   parameter int AddressWidth = 10,
   parameter int DataWidth    = 32
);
   localparam int BeWidth = DataWidth / 8;

   logic                    if_req_i;
   logic [AddressWidth-1:0] if_addr_i;
   logic                    if_gnt_o;
   logic                    if_rvalid_o;
   logic [DataWidth-1:0]    if_rdata_o;

   logic                    dm_req_i;
   logic                    dm_we_i;
   logic [BeWidth-1:0]      dm_be_i;
   logic [AddressWidth-1:0] dm_addr_i;
   logic [DataWidth-1:0]    dm_wdata_i;
   logic                    dm_gnt_o;
   logic                    dm_rvalid_o;
   logic [DataWidth-1:0]    dm_rdata_o;

   logic                    mem_req_o;
   logic                    mem_we_o;
   logic [BeWidth-1:0]      mem_be_o;
   logic [AddressWidth-1:0] mem_addr_o;
   logic [DataWidth-1:0]    mem_wdata_o;
   logic [DataWidth-1:0]    mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
      output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
      input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (DM).
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is DM-over-IF priority.
//
// state   | meaning
// IDLE    | no access outstanding, grant window open
// WAIT    | access outstanding; cnt == 0 is the response cycle (grant window open again)
module unified_mem_arbiter #(
   parameter int AddressWidth = 10,
   parameter int DataWidth    = 32,
   parameter int MemLatency   = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   unified_mem_arbiter_if.slave  bus
);
   localparam int CntW = (MemLatency > 1) ? $clog2(MemLatency) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(MemLatency - 1);
   localparam logic OwnIf = 1'b0;
   localparam logic OwnDm = 1'b1;

   if (MemLatency < 1) begin : g_bad_latency
      $fatal(1, "unified_mem_arbiter: MemLatency must be >= 1");
   end

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t           state;
   logic [CntW-1:0]  cnt;
   logic             owner;
   logic             owner_we;

   logic                    resp_cycle;
   logic                    window;
   logic                    dm_wins;
   logic                    gnt_if;
   logic                    gnt_dm;
   logic [AddressWidth-1:0] addr_sel;
   logic [DataWidth-1:0]    wdata_sel;

   assign resp_cycle = (state == ST_WAIT) && (cnt == '0);
   // Gating with rst_ni keeps every output low while reset is held.
   assign window     = rst_ni && ((state == ST_IDLE) || resp_cycle);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_owner;
   assign dm_wins = bus.dm_req_i && (!bus.if_req_i || (last_owner == OwnIf));
`else
   assign dm_wins = bus.dm_req_i;
`endif

   assign gnt_dm    = window && dm_wins;
   assign gnt_if    = window && bus.if_req_i && !dm_wins;
   assign addr_sel  = gnt_dm ? bus.dm_addr_i : (gnt_if ? bus.if_addr_i : '0);
   assign wdata_sel = gnt_dm ? bus.dm_wdata_i : '0;

   assign bus.if_gnt_o    = gnt_if;
   assign bus.dm_gnt_o    = gnt_dm;
   assign bus.mem_req_o   = gnt_if || gnt_dm;
   assign bus.mem_we_o    = gnt_dm && bus.dm_we_i;
   assign bus.mem_be_o    = gnt_dm ? bus.dm_be_i : '0;
   assign bus.mem_addr_o  = addr_sel;
   assign bus.mem_wdata_o = wdata_sel;

   assign bus.if_rvalid_o = resp_cycle && (owner == OwnIf);
   assign bus.dm_rvalid_o = resp_cycle && (owner == OwnDm);
   assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
   assign bus.dm_rdata_o  = (bus.dm_rvalid_o && !owner_we) ? bus.mem_rdata_i : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         owner    <= OwnIf;
         owner_we <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_owner <= OwnIf;
`endif
      end else begin
         if (gnt_if || gnt_dm) begin
            state    <= ST_WAIT;
            cnt      <= CntLoad;
            owner    <= gnt_dm ? OwnDm : OwnIf;
            owner_we <= gnt_dm && bus.dm_we_i;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= gnt_dm ? OwnDm : OwnIf;
`endif
         end else if (resp_cycle) begin
            state <= ST_IDLE;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scoreboard bench for unified_mem_arbiter; one DUT per MemLatency 1..4 sharing stimulus.
module tb_unified_mem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          dm_req;
   logic          dm_we;
   logic [BW-1:0] dm_be;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;

   logic          if_gnt_a   [4];
   logic          dm_gnt_a   [4];
   logic          if_rv_a    [4];
   logic          dm_rv_a    [4];
   logic [DW-1:0] if_rdata_a [4];
   logic [DW-1:0] dm_rdata_a [4];
   logic          mem_req_a  [4];
   logic          mem_we_a   [4];
   logic [BW-1:0] mem_be_a   [4];
   logic [AW-1:0] mem_addr_a [4];
   logic [DW-1:0] mem_wdata_a[4];

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      case (a)
         10'h000: return 32'h00000013;
         10'h001: return 32'h00100093;
         10'h002: return 32'h00200113;
         10'h3FF: return 32'hDEADBEEF;
         default: return 32'hA5A50000 | 32'(a);
      endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      unified_mem_arbiter_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();
      logic [DW-1:0] pipe [4];

      unified_mem_arbiter #(
         .AddressWidth(AW), .DataWidth(DW), .MemLatency(g + 1)
      ) dut (
         .clk_i (clk),
         .rst_ni(rst_n),
         .bus   (bus)
      );

      assign bus.if_req_i   = if_req;
      assign bus.if_addr_i  = if_addr;
      assign bus.dm_req_i   = dm_req;
      assign bus.dm_we_i    = dm_we;
      assign bus.dm_be_i    = dm_be;
      assign bus.dm_addr_i  = dm_addr;
      assign bus.dm_wdata_i = dm_wdata;

      // Fixed-latency read-only memory model: data appears g+1 cycles after the strobe.
      always_ff @(posedge clk) begin
         pipe[0] <= (bus.mem_req_o && !bus.mem_we_o) ? mem_val(bus.mem_addr_o) : '0;
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign bus.mem_rdata_i = pipe[g];

      assign if_gnt_a[g]    = bus.if_gnt_o;
      assign dm_gnt_a[g]    = bus.dm_gnt_o;
      assign if_rv_a[g]     = bus.if_rvalid_o;
      assign dm_rv_a[g]     = bus.dm_rvalid_o;
      assign if_rdata_a[g]  = bus.if_rdata_o;
      assign dm_rdata_a[g]  = bus.dm_rdata_o;
      assign mem_req_a[g]   = bus.mem_req_o;
      assign mem_we_a[g]    = bus.mem_we_o;
      assign mem_be_a[g]    = bus.mem_be_o;
      assign mem_addr_a[g]  = bus.mem_addr_o;
      assign mem_wdata_a[g] = bus.mem_wdata_o;
   end

   typedef struct {
      int            due;
      logic          port;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   sel;
   int   cyc;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (dut L=%0d cycle %0d)", tag, obs, exp, sel + 1, cyc);
      end
   endtask

   task automatic check_quiet(input string tag, input int g);
      check({tag, "_if_gnt"},    32'(if_gnt_a[g]),  '0);
      check({tag, "_dm_gnt"},    32'(dm_gnt_a[g]),  '0);
      check({tag, "_if_rvalid"}, 32'(if_rv_a[g]),   '0);
      check({tag, "_dm_rvalid"}, 32'(dm_rv_a[g]),   '0);
      check({tag, "_if_rdata"},  if_rdata_a[g],     '0);
      check({tag, "_dm_rdata"},  dm_rdata_a[g],     '0);
      check({tag, "_mem_req"},   32'(mem_req_a[g]), '0);
      check({tag, "_mem_we"},    32'(mem_we_a[g]),  '0);
      check({tag, "_mem_be"},    32'(mem_be_a[g]),  '0);
      check({tag, "_mem_addr"},  32'(mem_addr_a[g]), '0);
      check({tag, "_mem_wdata"}, mem_wdata_a[g],    '0);
   endtask

   // One clock cycle on the selected DUT: inputs are already driven, eig/edg are the expected grants.
   task automatic tick(input logic eig, input logic edg);
      exp_t e;
      @(negedge clk);
      check("if_gnt",  32'(if_gnt_a[sel]),  32'(eig));
      check("dm_gnt",  32'(dm_gnt_a[sel]),  32'(edg));
      check("mem_req", 32'(mem_req_a[sel]), 32'(eig | edg));
      if (eig | edg) begin
         check("mem_addr", 32'(mem_addr_a[sel]), 32'(edg ? dm_addr : if_addr));
         check("mem_we",   32'(mem_we_a[sel]),   32'(edg & dm_we));
         check("mem_be",   32'(mem_be_a[sel]),   32'(edg ? dm_be : '0));
         if (edg && dm_we) check("mem_wdata", mem_wdata_a[sel], dm_wdata);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check("if_rvalid", 32'(if_rv_a[sel]), 32'(!e.port));
         check("dm_rvalid", 32'(dm_rv_a[sel]), 32'(e.port));
         if (e.port) check("dm_rdata", dm_rdata_a[sel], e.data);
         else        check("if_rdata", if_rdata_a[sel], e.data);
      end else begin
         check("if_rvalid_none", 32'(if_rv_a[sel]), '0);
         check("dm_rvalid_none", 32'(dm_rv_a[sel]), '0);
      end
      if (edg) begin
         e.due = cyc + sel + 1; e.port = 1'b1;
         e.data = dm_we ? '0 : mem_val(dm_addr);
         sb.push_back(e);
      end else if (eig) begin
         e.due = cyc + sel + 1; e.port = 1'b0;
         e.data = mem_val(if_addr);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      sel = 0;
      cyc = 0;
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < 4; g++) check_quiet("reset", g);
      do_reset();

      // IF only, MemLatency 1: back-to-back fetch
      sel = 0;
      if_req = 1'b1;
      if_addr = 10'h000; tick(1'b1, 1'b0);
      if_addr = 10'h001; tick(1'b1, 1'b0);
      if_addr = 10'h002; tick(1'b1, 1'b0);
      if_req = 1'b0;     tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      // Single DM read, MemLatency 3
      sel = 2; do_reset();
      dm_req = 1'b1; dm_addr = 10'h3FF; tick(1'b0, 1'b1);
      dm_req = 1'b0;
      repeat (4) tick(1'b0, 1'b0);

      // DM write, MemLatency 1
      sel = 0; do_reset();
      dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_wdata = 32'h1234ABCD; dm_addr = 10'h010;
      tick(1'b0, 1'b1);
      dm_req = 1'b0;
      tick(1'b0, 1'b0);
      dm_we = 1'b0;
      tick(1'b0, 1'b0);

      // Sustained conflict, MemLatency 1
      sel = 0; do_reset();
      if_req = 1'b1; if_addr = 10'h005; dm_req = 1'b1; dm_addr = 10'h3FF;
`ifdef ARB_ROUND_ROBIN_EN
      tick(1'b0, 1'b1); tick(1'b1, 1'b0); tick(1'b0, 1'b1); tick(1'b1, 1'b0);
`else
      tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b1);
`endif
      if_req = 1'b0; dm_req = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      // Reset mid-access, MemLatency 4
      sel = 3; do_reset();
      dm_req = 1'b1; dm_addr = 10'h020; tick(1'b0, 1'b1);
      dm_req = 1'b0; tick(1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      dm_req = 1'b1;
      #1;
      check_quiet("midrst", sel);
      sb.delete();
      dm_req = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b1;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      dm_req = 1'b1; dm_addr = 10'h3FF; tick(1'b0, 1'b1);
      dm_req = 1'b0;
      repeat (5) tick(1'b0, 1'b0);

      // Request withdrawn during WAIT, MemLatency 2
      sel = 1; do_reset();
      dm_req = 1'b1; dm_addr = 10'h001; tick(1'b0, 1'b1);
      dm_req = 1'b0; if_req = 1'b1; if_addr = 10'h002; tick(1'b0, 1'b0);
      if_req = 1'b0; tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
